// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the 5-stage MIPS core front end.
//   PC_W       byte-address width of PC / pc_4 buses
//   INSTR_W    instruction width
//   NOP_INSTR  encoding used for an IF/ID bubble
//   RESET_PC   PC loaded on reset
//   if_state_t fetch-stage control states
package mips_pkg;

  localparam int unsigned PC_W    = 12;
  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [11:0] RESET_PC  = 12'h000;

  // BOOT: waiting for the first go; RUN: fetching; HALTED: sticky until reset.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg -- IF/ID pipeline register carrying {pc+4, instruction, valid}.
// Ports:
//   clk      core clock, all state on posedge
//   rst_n    synchronous active-low reset, clears to a bubble
//   load_i   capture pc_4_i / instr_i and mark the slot valid
//   flush_i  replace contents with a bubble (wins over load_i)
//   pc_4_i   pc+4 of the instruction being captured
//   instr_i  instruction being captured
//   pc_4_o   registered pc+4
//   instr_o  registered instruction (NOP_INSTR when bubble)
//   valid_o  registered valid flag
// With neither load_i nor flush_i asserted the register holds.
module if_id_reg #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_4_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_4_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);
  import mips_pkg::*;

  logic [PC_W-1:0]    pc_4_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      pc_4_q  <= '0;
      instr_q <= NOP_INSTR[INSTR_W-1:0];
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_4_q  <= pc_4_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_4_o  = pc_4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage plus IF/ID register of the MIPS core.
// Ports:
//   clk             core clock, all state on posedge
//   rst_n           synchronous reset, active low
//   go              global advance enable; 0 freezes every register here
//   stall           load-use hazard from ID: hold PC and IF/ID
//   redirect_valid  taken branch/jump resolved in EXE (beats stall)
//   redirect_pc     redirect byte address, bits [1:0] forced to zero
//   halt_req        syscall-halt from WB, enters sticky HALTED
//   imem_addr       word address to combinational instruction ROM
//   imem_rdata      ROM data for imem_addr, same cycle
//   pc_4_out        registered pc+4 of instruction_out
//   instruction_out registered instruction (0 = bubble)
//   valid_out       instruction_out is a real fetched instruction
//   halted          high only in HALTED
//   stall_cnt       (IF_PERF_CNT_EN) saturating count of stall cycles in RUN
//   flush_cnt       (IF_PERF_CNT_EN) saturating count of redirect cycles in RUN
// Build option: define IF_PERF_CNT_EN to add the performance counters.
module if_stage #(
  parameter int unsigned       PC_W     = mips_pkg::PC_W,
  parameter int unsigned       INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = mips_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic [PC_W-3:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc_4_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               valid_out,
  output logic               halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);
  import mips_pkg::*;

  if_state_t       state_q;
  logic            halted_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic            run_go;
  logic            ifid_load;
  logic            ifid_flush;

  // Wraps modulo 2^PC_W with no carry out.
  assign pc_plus4 = pc_q + PC_W'(4);
  assign run_go   = go && (state_q == RUN);

  // Next-PC select and IF/ID control; only meaningful while running.
  // Redirect beats stall, stall beats sequential fetch.
  always_comb begin
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (run_go) begin
      if (redirect_valid) begin
        pc_d       = redirect_pc & ~PC_W'(3);
        ifid_flush = 1'b1;
      end else if (!stall) begin
        pc_d       = pc_plus4;
        ifid_load  = 1'b1;
      end
    end
  end

  // Control FSM and PC. A halt request still lets this edge's
  // redirect/stall/fetch take effect; HALTED freezes from the next edge on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
      pc_q     <= RESET_PC;
    end else if (go) begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN: begin
          pc_q <= pc_d;
          if (halt_req) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_4_i  (pc_plus4),
    .instr_i (imem_rdata),
    .pc_4_o  (pc_4_out),
    .instr_o (instruction_out),
    .valid_o (valid_out)
  );

  assign imem_addr = pc_q[PC_W-1:2];
  assign halted    = halted_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (run_go) begin
      if (redirect_valid) begin
        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
      end else if (stall) begin
        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, go, stall, redirect_valid, halt_req;
  logic [11:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] pc_4_out;
  logic [31:0] instruction_out;
  logic        valid_out, halted;
  logic [31:0] stall_cnt, flush_cnt;

  logic [31:0] rom [0:1023];
  assign imem_rdata = rom[imem_addr];

  always #5 clk = ~clk;

  if_stage #(
    .PC_W     (12),
    .INSTR_W  (32),
    .RESET_PC (12'h000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .go              (go),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt_req        (halt_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .pc_4_out        (pc_4_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .halted          (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

`ifndef IF_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = waiting for go, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [11:0] m_pc, m_pc4;
  logic [31:0] m_ins, m_sc, m_fc;
  logic        m_v;

  // Apply one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic g, input logic s, input logic rv,
                      input logic [11:0] rp, input logic h);
    rst_n = r; go = g; stall = s; redirect_valid = rv; redirect_pc = rp; halt_req = h;
    if (!r) begin
      m_mode = 0; m_pc = 12'h000; m_pc4 = 12'h000; m_ins = 0; m_v = 1'b0; m_sc = 0; m_fc = 0;
    end else if (g) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rv) begin
          m_pc = rp & 12'hFFC; m_pc4 = 0; m_ins = 0; m_v = 1'b0;
          if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end else if (s) begin
          if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else begin
          m_ins = rom[m_pc / 4];
          m_pc  = m_pc + 12'd4;
          m_pc4 = m_pc;
          m_v   = 1'b1;
        end
        if (h) m_mode = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic norm();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) rom[i] = i + 1;
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 1'b1);
    total++;
    if ({imem_addr, pc_4_out, instruction_out, valid_out, halted} !== {10'd0, 12'd0, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got addr=%h pc4=%h ins=%h v=%b h=%b exp all zero",
               imem_addr, pc_4_out, instruction_out, valid_out, halted);
    end
    total++;
    if ({stall_cnt, flush_cnt} !== 64'd0) begin
      bad++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt);
    end
    // go=0 in BOOT: nothing moves.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1, 12'h080, 1'b1);
      total++;
      if ({imem_addr, valid_out, halted} !== {10'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL boot_hold: got addr=%h v=%b h=%b exp 0 0 0", imem_addr, valid_out, halted);
      end
    end
  endtask

  task automatic test_fetch();
    do_reset();
    norm();
    total++;
    if ({imem_addr, instruction_out, valid_out} !== {10'd0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL boot_bubble: got addr=%h ins=%h v=%b exp 0 0 0", imem_addr, instruction_out, valid_out);
    end
    for (int i = 1; i <= 3; i++) begin
      norm();
      total++;
      if ({instruction_out, pc_4_out, valid_out} !== {32'(i), 12'(4 * i), 1'b1}) begin
        bad++;
        $display("FAIL fetch_%0d: got ins=%h pc4=%h v=%b exp ins=%h pc4=%h v=1",
                 i, instruction_out, pc_4_out, valid_out, i, 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    norm(); norm(); norm();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
      total++;
      if ({imem_addr, pc_4_out, instruction_out, valid_out} !== {10'd2, 12'd8, 32'd2, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold_%0d: got addr=%h pc4=%h ins=%h v=%b exp 2 8 2 1",
                 i, imem_addr, pc_4_out, instruction_out, valid_out);
      end
    end
    norm();
    total++;
    if ({pc_4_out, instruction_out} !== {12'd12, 32'd3}) begin
      bad++;
      $display("FAIL stall_resume: got pc4=%h ins=%h exp c 3", pc_4_out, instruction_out);
    end
`ifdef IF_PERF_CNT_EN
    total++;
    if (stall_cnt !== 32'd3) begin
      bad++;
      $display("FAIL stall_cnt: got %0d exp 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_redirect();
    do_reset();
    norm(); norm();
    tick(1'b1, 1'b1, 1'b1, 1'b1, 12'h043, 1'b0);
    total++;
    if ({imem_addr, pc_4_out, instruction_out, valid_out} !== {10'd16, 12'd0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL redirect_bubble: got addr=%h pc4=%h ins=%h v=%b exp 10 0 0 0",
               imem_addr, pc_4_out, instruction_out, valid_out);
    end
    norm();
    total++;
    if ({pc_4_out, instruction_out, valid_out} !== {12'h044, 32'd17, 1'b1}) begin
      bad++;
      $display("FAIL redirect_fetch: got pc4=%h ins=%h v=%b exp 44 11 1", pc_4_out, instruction_out, valid_out);
    end
`ifdef IF_PERF_CNT_EN
    total++;
    if ({flush_cnt, stall_cnt} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL flush_cnt: got flush=%0d stall=%0d exp 1 0", flush_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    norm();
    tick(1'b1, 1'b1, 1'b0, 1'b1, 12'hFFC, 1'b0);
    norm();
    total++;
    if ({pc_4_out, instruction_out, imem_addr} !== {12'h000, 32'd1024, 10'd0}) begin
      bad++;
      $display("FAIL pc_wrap: got pc4=%h ins=%h addr=%h exp 0 400 0", pc_4_out, instruction_out, imem_addr);
    end
    norm();
    total++;
    if ({pc_4_out, instruction_out} !== {12'h004, 32'd1}) begin
      bad++;
      $display("FAIL after_wrap: got pc4=%h ins=%h exp 4 1", pc_4_out, instruction_out);
    end
  endtask

  task automatic test_halt();
    do_reset();
    norm();
    for (int i = 0; i < 5; i++) norm();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
    total++;
    if ({halted, instruction_out, pc_4_out, imem_addr} !== {1'b1, 32'd6, 12'd24, 10'd6}) begin
      bad++;
      $display("FAIL halt_enter: got h=%b ins=%h pc4=%h addr=%h exp 1 6 18 6",
               halted, instruction_out, pc_4_out, imem_addr);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           12'($urandom), 1'($urandom_range(0, 1)));
      total++;
      if ({halted, instruction_out, pc_4_out, imem_addr, valid_out} !== {1'b1, 32'd6, 12'd24, 10'd6, 1'b1}) begin
        bad++;
        $display("FAIL halt_frozen_%0d: got h=%b ins=%h pc4=%h addr=%h v=%b", i,
                 halted, instruction_out, pc_4_out, imem_addr, valid_out);
      end
    end
    do_reset();
    total++;
    if ({halted, imem_addr, valid_out} !== {1'b0, 10'd0, 1'b0}) begin
      bad++;
      $display("FAIL halt_reset: got h=%b addr=%h v=%b exp 0 0 0", halted, imem_addr, valid_out);
    end
  endtask

  task automatic test_go_gating();
    do_reset();
    norm(); norm(); norm(); norm();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 12'h100, 1'($urandom_range(0, 1)));
      total++;
      if ({imem_addr, instruction_out, pc_4_out, halted} !== {10'd3, 32'd3, 12'd12, 1'b0}) begin
        bad++;
        $display("FAIL go_hold_%0d: got addr=%h ins=%h pc4=%h h=%b exp 3 3 c 0",
                 i, imem_addr, instruction_out, pc_4_out, halted);
      end
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1, 12'h100, 1'b0);
    total++;
    if ({imem_addr, valid_out} !== {10'h040, 1'b0}) begin
      bad++;
      $display("FAIL go_redirect: got addr=%h v=%b exp 40 0", imem_addr, valid_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 99) < 80),
           1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 15),
           12'($urandom), 1'($urandom_range(0, 99) < 2));
      total++;
      if ({imem_addr, pc_4_out, instruction_out, valid_out, halted} !==
          {m_pc[11:2], m_pc4, m_ins, m_v, 1'(m_mode == 2)}) begin
        bad++;
        $display("FAIL random_%0d: got addr=%h pc4=%h ins=%h v=%b h=%b exp addr=%h pc4=%h ins=%h v=%b h=%b",
                 i, imem_addr, pc_4_out, instruction_out, valid_out, halted,
                 m_pc[11:2], m_pc4, m_ins, m_v, (m_mode == 2));
      end
`ifdef IF_PERF_CNT_EN
      total++;
      if ({stall_cnt, flush_cnt} !== {m_sc, m_fc}) begin
        bad++;
        $display("FAIL random_cnt_%0d: got stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, m_sc, m_fc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_go_gating();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
